// File: rtl/ram_fifo_ctrl_pkg.sv
// Shared definitions for the register-file RAM FIFO sequencer.
// State codes and the default RAM geometry.
package ram_fifo_ctrl_pkg;

    localparam int unsigned RAM_DW    = 16;
    localparam int unsigned RAM_AW    = 3;
    localparam int unsigned RAM_DEPTH = 1 << RAM_AW;

    typedef enum logic {
        StInit = 1'b0,
        StRun  = 1'b1
    } state_e;

endpackage

// File: rtl/ram_fifo_ctrl_wrap_ctr.sv
// AW-bit wrapping counter with asynchronous active-low clear and increment enable.
// Used for the write pointer, read pointer and zero-sweep address.
module ram_fifo_ctrl_wrap_ctr #(
    parameter int unsigned AW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    output logic [AW-1:0] q
);

    logic [AW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (inc) begin
            cnt_q <= cnt_q + AW'(1);
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/ram_fifo_ctrl.sv
// Sequencer that drives the 8x16 register-file RAM as an 8-deep FIFO.
// Zeroes every RAM word after reset, then arbitrates push/pop onto the single shared address.
module ram_fifo_ctrl
    import ram_fifo_ctrl_pkg::*;
#(
    parameter int unsigned DW = RAM_DW,
    parameter int unsigned AW = RAM_AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    output logic          push_ready,
    input  logic          pop,
    output logic          pop_ready,
    output logic [DW-1:0] pop_data,
    input  logic [DW-1:0] ram_rdata,
    output logic [DW-1:0] ram_wdata,
    output logic          ram_a2,
    output logic          ram_a1,
    output logic          ram_a0,
    output logic          ram_en,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty,
    output logic          init_done,
    output logic          overflow,
    output logic          underflow
);

    localparam int unsigned DEPTH     = 1 << AW;
    localparam logic [AW:0] FullCount = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);

    state_e        state_q, state_d;
    logic [AW:0]   count_q, count_d;
    logic          full_q, empty_q, init_done_q, overflow_q, underflow_q;
    logic [AW-1:0] wr_ptr, rd_ptr, init_cnt, addr;
    logic          run, push_acc, pop_acc, init_last;

    ram_fifo_ctrl_wrap_ctr #(.AW(AW)) u_wr_ptr (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (push_acc),
        .q    (wr_ptr)
    );

    ram_fifo_ctrl_wrap_ctr #(.AW(AW)) u_rd_ptr (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (pop_acc),
        .q    (rd_ptr)
    );

    ram_fifo_ctrl_wrap_ctr #(.AW(AW)) u_init_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (~run),
        .q    (init_cnt)
    );

    always_comb begin
        run        = (state_q == StRun);
        // One RAM address per cycle: a pending pop blocks any push.
        pop_ready  = run & ~empty_q;
        push_ready = run & ~full_q & ~(pop & ~empty_q);
        pop_acc    = pop & pop_ready;
        push_acc   = push & push_ready;
        init_last  = (state_q == StInit) && (init_cnt == LastAddr);

        state_d = state_q;
        if (init_last) begin
            state_d = StRun;
        end

        count_d = count_q;
        if (push_acc) begin
            count_d = count_q + (AW + 1)'(1);
        end else if (pop_acc) begin
            count_d = count_q - (AW + 1)'(1);
        end

        if (!run) begin
            addr      = init_cnt;
            ram_en    = 1'b1;
            ram_wdata = '0;
        end else begin
            // Idle cycles park on the head so pop_data is always presented.
            addr      = push_acc ? wr_ptr : rd_ptr;
            ram_en    = push_acc;
            ram_wdata = push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StInit;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            init_done_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            full_q  <= (count_d == FullCount);
            empty_q <= (count_d == '0);
            if (init_last) begin
                init_done_q <= 1'b1;
            end
            if (run && push && full_q) begin
                overflow_q <= 1'b1;
            end
            if (run && pop && empty_q) begin
                underflow_q <= 1'b1;
            end
        end
    end

    assign ram_a2    = addr[2];
    assign ram_a1    = addr[1];
    assign ram_a0    = addr[0];
    assign pop_data  = ram_rdata;
    assign count     = count_q;
    assign full      = full_q;
    assign empty     = empty_q;
    assign init_done = init_done_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl with a behavioural 8x16 RAM and a queue-based FIFO reference.
// Directed scenarios pin literal values; a randomized phase is checked every cycle.
module tb_ram_fifo_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        push = 1'b0, pop = 1'b0;
    logic [15:0] push_data = '0;
    logic        push_ready, pop_ready;
    logic [15:0] pop_data, ram_rdata, ram_wdata;
    logic        ram_a2, ram_a1, ram_a0, ram_en;
    logic [3:0]  count;
    logic        full, empty, init_done, overflow, underflow;

    int checks = 0;
    int failures = 0;

    always #2 clk = ~clk;

    ram_fifo_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .push_ready(push_ready),
        .pop       (pop),
        .pop_ready (pop_ready),
        .pop_data  (pop_data),
        .ram_rdata (ram_rdata),
        .ram_wdata (ram_wdata),
        .ram_a2    (ram_a2),
        .ram_a1    (ram_a1),
        .ram_a0    (ram_a0),
        .ram_en    (ram_en),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .init_done (init_done),
        .overflow  (overflow),
        .underflow (underflow)
    );

    // Behavioural RAM: write on rising edge when enabled, combinational read at the same address.
    logic [15:0] mem [8];
    logic        scr_en = 1'b0;
    logic [2:0]  scr_addr = '0;
    logic [15:0] scr_data = '0;
    logic [2:0]  addr_w;
    assign addr_w    = {ram_a2, ram_a1, ram_a0};
    assign ram_rdata = mem[addr_w];

    always @(posedge clk) begin
        if (scr_en) mem[scr_addr] <= scr_data;
        else if (ram_en) mem[addr_w] <= ram_wdata;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: FIFO contents as a queue, head index, sweep progress.
    logic [15:0] mq[$];
    int          m_rd, m_init;
    bit          m_run, m_ovf, m_unf;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_rd = 0; m_init = 0; m_run = 0; m_ovf = 0; m_unf = 0;
        end else if (!m_run) begin
            m_init++;
            if (m_init == 8) begin
                m_run = 1; m_init = 0;
            end
        end else begin
            if (push && mq.size() == 8) m_ovf = 1;
            if (pop && mq.size() == 0) m_unf = 1;
            if (pop && mq.size() > 0) begin
                void'(mq.pop_front());
                m_rd = (m_rd + 1) % 8;
            end else if (push && mq.size() < 8) begin
                mq.push_back(push_data);
            end
        end
    end

    always @(negedge clk) begin
        int  sz;
        bit  e_pop_rdy, e_push_rdy, e_en;
        int  e_addr;
        if (rst_n) begin
            sz         = mq.size();
            e_pop_rdy  = m_run && sz > 0;
            e_push_rdy = m_run && sz < 8 && !(pop && sz > 0);
            e_en       = !m_run || (push && e_push_rdy);
            e_addr     = !m_run ? m_init : (push && e_push_rdy) ? (m_rd + sz) % 8 : m_rd;
            chk("pop_ready", 32'(pop_ready), 32'(e_pop_rdy));
            chk("push_ready", 32'(push_ready), 32'(e_push_rdy));
            chk("ram_en", 32'(ram_en), 32'(e_en));
            chk("ram_addr", 32'(addr_w), 32'(e_addr));
            chk("count", 32'(count), 32'(sz));
            chk("full", 32'(full), 32'(sz == 8));
            chk("empty", 32'(empty), 32'(sz == 0));
            chk("init_done", 32'(init_done), 32'(m_run));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            chk("underflow", 32'(underflow), 32'(m_unf));
            if (e_en) chk("ram_wdata", 32'(ram_wdata), m_run ? 32'(push_data) : 32'd0);
            if (pop && e_pop_rdy) chk("pop_data", 32'(pop_data), 32'(mq[0]));
        end
    end

    logic [15:0] snap_pop_data;
    logic        snap_push_ready, snap_pop_ready;

    // Called at posedge+1; returns at the next posedge+1 with the edge applied.
    task automatic step(input bit p, input logic [15:0] d, input bit q);
        push = p; push_data = d; pop = q;
        @(negedge clk);
        snap_pop_data   = pop_data;
        snap_push_ready = push_ready;
        snap_pop_ready  = pop_ready;
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0;
    endtask

    task automatic sweep_check(input string tag);
        for (int i = 0; i < 8; i++) begin
            chk({tag, "_addr"}, 32'(addr_w), 32'(i));
            chk({tag, "_en"}, 32'(ram_en), 32'd1);
            chk({tag, "_wdata"}, 32'(ram_wdata), 32'd0);
            chk({tag, "_busy"}, 32'(init_done), 32'd0);
            step(0, 16'h0, 0);
        end
        chk({tag, "_done"}, 32'(init_done), 32'd1);
        chk({tag, "_empty"}, 32'(empty), 32'd1);
        for (int i = 0; i < 8; i++) chk({tag, "_zero"}, 32'(mem[i]), 32'd0);
    endtask

    initial begin
        // Fill the RAM with garbage while in reset so the sweep is observable.
        scr_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            scr_addr = 3'(i); scr_data = 16'hdea0 + 16'(i);
            @(posedge clk); #1;
        end
        scr_en = 1'b0;
        rst_n  = 1'b1;

        sweep_check("init");

        // Simple in-order traffic.
        step(1, 16'd100, 0); step(1, 16'd222, 0); step(1, 16'd1, 0);
        chk("t2_count3", 32'(count), 32'd3);
        step(0, 0, 1); chk("t2_pop0", 32'(snap_pop_data), 32'd100); chk("t2_c2", 32'(count), 32'd2);
        step(0, 0, 1); chk("t2_pop1", 32'(snap_pop_data), 32'd222); chk("t2_c1", 32'(count), 32'd1);
        step(0, 0, 1); chk("t2_pop2", 32'(snap_pop_data), 32'd1);   chk("t2_c0", 32'(count), 32'd0);
        chk("t2_empty", 32'(empty), 32'd1);

        // Fill to full, overflow, then drain.
        for (int i = 0; i < 8; i++) step(1, 16'(10 + i), 0);
        chk("t3_full", 32'(full), 32'd1);
        chk("t3_push_ready", 32'(push_ready), 32'd0);
        step(1, 16'd99, 0);
        chk("t3_overflow", 32'(overflow), 32'd1);
        chk("t3_count", 32'(count), 32'd8);
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 1);
            chk("t3_pop", 32'(snap_pop_data), 32'(10 + i));
        end

        // Pointer wrap.
        for (int i = 0; i < 5; i++) step(1, 16'(i + 1), 0);
        for (int i = 0; i < 5; i++) step(0, 0, 1);
        for (int i = 0; i < 8; i++) step(1, 16'h20 + 16'(i), 0);
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 1);
            chk("t4_pop", 32'(snap_pop_data), 32'h20 + 32'(i));
        end

        // Push and pop together: pop wins, push lands the next cycle.
        step(1, 16'h30, 0); step(1, 16'h31, 0);
        step(1, 16'h32, 1);
        chk("t5_push_stalled", 32'(snap_push_ready), 32'd0);
        chk("t5_pop", 32'(snap_pop_data), 32'h30);
        chk("t5_c1", 32'(count), 32'd1);
        step(1, 16'h32, 0);
        chk("t5_c2", 32'(count), 32'd2);
        step(0, 0, 1); chk("t5_pop1", 32'(snap_pop_data), 32'h31);
        step(0, 0, 1); chk("t5_pop2", 32'(snap_pop_data), 32'h32);

        // Underflow, then reset mid-stream.
        step(0, 0, 1);
        chk("t6_pop_ready", 32'(snap_pop_ready), 32'd0);
        chk("t6_underflow", 32'(underflow), 32'd1);
        chk("t6_count", 32'(count), 32'd0);
        step(1, 16'h40, 0); step(1, 16'h41, 0);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_count", 32'(count), 32'd0);
        chk("t6_rst_ovf", 32'(overflow), 32'd0);
        chk("t6_rst_unf", 32'(underflow), 32'd0);
        chk("t6_rst_done", 32'(init_done), 32'd0);
        chk("t6_rst_push_ready", 32'(push_ready), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        sweep_check("resweep");

        // Randomized traffic with shifting push/pop bias and occasional resets.
        begin
            int pp, pq;
            pp = 50; pq = 50;
            for (int n = 0; n < 3000; n++) begin
                if (n % 64 == 0) begin
                    pp = int'($urandom_range(10, 90));
                    pq = int'($urandom_range(10, 90));
                end
                if ($urandom_range(0, 399) == 0) begin
                    rst_n = 1'b0;
                    @(posedge clk); #1;
                    rst_n = 1'b1;
                end
                step(int'($urandom_range(0, 99)) < pp, 16'($urandom), int'($urandom_range(0, 99)) < pq);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
